// File: rtl/ooo_pkg.sv
// ============================================================================
// Module  : ooo_pkg
// Brief   : Shared widths and fetch state encoding for the fetch front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ooo_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_DONE = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
// Module  : ifq_fifo
// Brief   : DEPTH-entry synchronous FIFO with occupancy count and show-ahead head.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ifq_fifo
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2 * XLEN,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             w_rd_fire;
    logic             w_wr_fire;

    // A write into a full FIFO is accepted when the head leaves in the same cycle.
    assign w_rd_fire = rd_en && (count_q != '0);
    assign w_wr_fire = wr_en && ((count_q != FULL_CNT) || w_rd_fire);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(w_wr_fire) - CW'(w_rd_fire);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign empty   = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/instr_fetch_queue.sv
// ============================================================================
// Module  : instr_fetch_queue
// Brief   : PC generator + instruction queue in front of a 1-cycle memory.
//           Define IFQ_STATS_EN to add the saturating stall_cnt output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_fetch_queue
    import ooo_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [XLEN-1:0] pc_o,
    input  logic [XLEN-1:0] im_instr_i,
    input  logic            im_stop_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            fetch_done
`ifdef IFQ_STATS_EN
    ,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pend_q, pend_d;
    logic            fetch_done_q;

    logic [CW-1:0]   w_count;
    logic            w_empty;
    logic [2*XLEN-1:0] w_head;
    logic            w_pc_ok;
    logic            w_room_ok;
    logic            w_live;
    logic            w_rsp;
    logic            w_enq;
    logic [XLEN-1:0] w_rsp_pc;

    // Widened compare keeps pc + 3 from wrapping near the top of the address space.
    assign w_pc_ok   = ({1'b0, pc_q} + 33'd3) < 33'(MEM_BYTES);
    assign w_room_ok = (w_count + CW'(pend_q)) < CW'(DEPTH);
    assign w_live    = (state_q == FETCH_RUN) && w_pc_ok && w_room_ok;

    // Responses arriving after DONE belong to cancelled requests.
    assign w_rsp     = pend_q && (state_q == FETCH_RUN);
    assign w_enq     = w_rsp && !im_stop_i;
    assign w_rsp_pc  = pc_q - XLEN'(INSTR_BYTES);

    always_comb begin
        pc_d    = pc_q;
        pend_d  = w_live;
        state_d = state_q;
        if (w_live) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
        if (state_q == FETCH_RUN) begin
            if (w_rsp && im_stop_i) begin
                state_d = FETCH_DONE;
            end else if (!pend_q && !w_pc_ok) begin
                state_d = FETCH_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FETCH_RUN;
            pc_q         <= RESET_PC;
            pend_q       <= 1'b0;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            fetch_done_q <= (state_d == FETCH_DONE);
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (w_enq),
        .wr_data ({w_rsp_pc, im_instr_i}),
        .rd_en   (out_ready),
        .rd_data (w_head),
        .count   (w_count),
        .empty   (w_empty)
    );

    assign pc_o       = pc_q;
    assign out_valid  = !w_empty;
    assign out_instr  = w_head[XLEN-1:0];
    assign out_pc     = w_head[2*XLEN-1:XLEN];
    assign fetch_done = fetch_done_q;

`ifdef IFQ_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
// ============================================================================
// Module  : tb_instr_fetch_queue
// Brief   : Directed self-checking bench for instr_fetch_queue.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_queue;

    logic        clk;
    logic        rstn;
    logic [31:0] pc;
    logic [31:0] im_instr;
    logic        im_stop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_done;

    logic [31:0] lim_pc;
    logic [31:0] lim_im_instr;
    logic        lim_im_stop;
    logic        lim_valid;
    logic        lim_ready;
    logic [31:0] lim_instr;
    logic [31:0] lim_out_pc;
    logic        lim_done;

`ifdef IFQ_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] lim_stall_cnt;
`endif

    logic [31:0] zero_pc;
    int          checks;
    int          failures;

    instr_fetch_queue #(
        .DEPTH     (4),
        .RESET_PC  (32'h0),
        .MEM_BYTES (1024)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc_o       (pc),
        .im_instr_i (im_instr),
        .im_stop_i  (im_stop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .fetch_done (fetch_done)
`ifdef IFQ_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    instr_fetch_queue #(
        .DEPTH     (4),
        .RESET_PC  (32'h0),
        .MEM_BYTES (16)
    ) dut_lim (
        .clk        (clk),
        .rstn       (rstn),
        .pc_o       (lim_pc),
        .im_instr_i (lim_im_instr),
        .im_stop_i  (lim_im_stop),
        .out_valid  (lim_valid),
        .out_ready  (lim_ready),
        .out_instr  (lim_instr),
        .out_pc     (lim_out_pc),
        .fetch_done (lim_done)
`ifdef IFQ_STATS_EN
        ,
        .stall_cnt  (lim_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == zero_pc) return 32'h0;
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory with one-cycle registered read.
    always @(posedge clk) begin
        im_instr     <= word_at(pc);
        im_stop      <= (word_at(pc) == 32'h0);
        lim_im_instr <= word_at(lim_pc);
        lim_im_stop  <= (word_at(lim_pc) == 32'h0);
    end

    // Leaves the bench at the negedge where cycle 0 begins.
    task automatic apply_reset();
        rstn      = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h expected 0", out_instr); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc: got %h expected 0", out_pc); end
        checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", fetch_done); end
        checks++; if (lim_done !== 1'b0) begin failures++; $display("FAIL reset_lim_done: got %b expected 0", lim_done); end
    endtask

    task automatic test_steady();
        logic [31:0] exp_pc;
        apply_reset();
        out_ready = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL steady_valid_c1: got %b expected 0", out_valid); end
            end else begin
                exp_pc = 32'((cyc - 2) * 4);
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL steady_valid c%0d: got %b expected 1", cyc, out_valid); end
                checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL steady_pc c%0d: got %h expected %h", cyc, out_pc, exp_pc); end
                checks++; if (out_instr !== word_at(exp_pc)) begin failures++; $display("FAIL steady_instr c%0d: got %h expected %h", cyc, out_instr, word_at(exp_pc)); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int          hs;
        apply_reset();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc >= 2) begin
                checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid c%0d: got %b expected 1", cyc, out_valid); end
                checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL bp_head c%0d: got %h expected 0", cyc, out_pc); end
            end
            if (cyc == 5 || cyc == 9) begin
                checks++; if (pc !== 32'd16) begin failures++; $display("FAIL bp_pc_freeze c%0d: got %h expected %h", cyc, pc, 32'd16); end
            end
        end
        out_ready = 1'b1;
        exp_pc    = 32'h0;
        hs        = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid && out_ready) begin
                checks++; if (out_pc !== exp_pc) begin failures++; $display("FAIL bp_order: got %h expected %h", out_pc, exp_pc); end
                exp_pc = exp_pc + 32'd4;
                hs++;
            end
            @(negedge clk);
        end
        checks++; if (hs !== 20) begin failures++; $display("FAIL bp_handshakes: got %0d expected 20", hs); end
    endtask

    task automatic test_stop();
        int hs;
        zero_pc = 32'd8;
        apply_reset();
        out_ready = 1'b1;
        hs = 0;
        for (int cyc = 0; cyc <= 11; cyc++) begin
            if (cyc == 3) begin
                checks++; if (fetch_done !== 1'b0) begin failures++; $display("FAIL stop_done_c3: got %b expected 0", fetch_done); end
            end
            if (cyc == 4 || cyc == 11) begin
                checks++; if (fetch_done !== 1'b1) begin failures++; $display("FAIL stop_done c%0d: got %b expected 1", cyc, fetch_done); end
            end
            if (out_valid) begin
                checks++;
                if (hs >= 2) begin
                    failures++; $display("FAIL stop_extra c%0d: got pc %h expected no entry", cyc, out_pc);
                end else if (out_pc !== 32'(hs * 4)) begin
                    failures++; $display("FAIL stop_pc c%0d: got %h expected %h", cyc, out_pc, 32'(hs * 4));
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++; if (hs !== 2) begin failures++; $display("FAIL stop_count: got %0d expected 2", hs); end
        checks++; if (pc !== 32'd16) begin failures++; $display("FAIL stop_pc_final: got %h expected %h", pc, 32'd16); end
        zero_pc = 32'hFFFF_FFFF;
    endtask

    task automatic test_limit();
        int hs;
        apply_reset();
        hs = 0;
        for (int cyc = 0; cyc <= 11; cyc++) begin
            if (lim_pc > 32'd16) begin
                checks++; failures++; $display("FAIL limit_pc_over c%0d: got %h expected <= %h", cyc, lim_pc, 32'd16);
            end
            if (cyc == 5) begin
                checks++; if (lim_done !== 1'b0) begin failures++; $display("FAIL limit_done_c5: got %b expected 0", lim_done); end
            end
            if (cyc == 6 || cyc == 11) begin
                checks++; if (lim_done !== 1'b1) begin failures++; $display("FAIL limit_done c%0d: got %b expected 1", cyc, lim_done); end
            end
            if (lim_valid) begin
                checks++;
                if (hs >= 4) begin
                    failures++; $display("FAIL limit_extra c%0d: got pc %h expected no entry", cyc, lim_out_pc);
                end else if (lim_out_pc !== 32'(hs * 4)) begin
                    failures++; $display("FAIL limit_pc c%0d: got %h expected %h", cyc, lim_out_pc, 32'(hs * 4));
                end
                hs++;
            end
            @(negedge clk);
        end
        checks++; if (hs !== 4) begin failures++; $display("FAIL limit_count: got %0d expected 4", hs); end
        checks++; if (lim_pc !== 32'd16) begin failures++; $display("FAIL limit_pc_final: got %h expected %h", lim_pc, 32'd16); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (4) @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_valid_pre: got %b expected 1", out_valid); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid: got %b expected 0", out_valid); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL mid_async_pc: got %h expected 0", pc); end
        @(negedge clk);
        rstn      = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_c1_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_c2_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL mid_c2_pc: got %h expected 0", out_pc); end
    endtask

`ifdef IFQ_STATS_EN
    task automatic test_stats();
        apply_reset();
        checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL stats_reset: got %0d expected 0", stall_cnt); end
        repeat (9) @(negedge clk);
        out_ready = 1'b1;
        checks++; if (stall_cnt !== 32'd7) begin failures++; $display("FAIL stats_count: got %0d expected 7", stall_cnt); end
        repeat (2) @(negedge clk);
        checks++; if (stall_cnt !== 32'd7) begin failures++; $display("FAIL stats_hold: got %0d expected 7", stall_cnt); end
    endtask
`endif

    initial begin
        checks    = 0;
        failures  = 0;
        zero_pc   = 32'hFFFF_FFFF;
        rstn      = 1'b0;
        out_ready = 1'b0;
        lim_ready = 1'b1;
        test_reset();
        test_steady();
        test_backpressure();
        test_stop();
        test_limit();
        test_reset_mid();
`ifdef IFQ_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
